daq_pixel_packer: RTL and testbench

- Downstream of the 8-bit DAQ capture stage, in the pixel-clock domain.
- Takes the captured byte stream and the frame/line state code, and packs bytes into 32-bit words tagged with start-of-frame and end-of-line flags.
- Buffers the words in a small FIFO and hands them to the SPI transmit stage over a valid/ready handshake.
- Reports line count and FIFO overflow.

---
 rtl/daq_pixel_packer.sv | 180 ++++++++++++++++++
 tb/tb_daq_pixel_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/daq_pixel_packer.sv
// daq_pixel_packer
// Packs the 8-bit capture byte stream into 32-bit little-endian words tagged
// with {sof, eol}. Words are buffered in a first-word-fall-through FIFO and
// handed downstream over a valid/ready handshake.
//
// Build option: DAQ_PACK_HDR_EN
//   defined   - a header word {16'hA5A5, frame_cnt} (sof=1, eol=0) is pushed
//               on every FOT rising edge; data words carry sof=0.
//   undefined - the first data word after any FOT cycle carries sof=1.
//
// Ports:
//   sys_clk, sys_rst_n   pixel clock, synchronous active-low reset
//   data_in[7:0]         capture byte, valid one cycle after state==WR_EN
//   state[2:0]           FOT=001, WR_EN=010, ROT=100, other codes idle
//   out_data[33:0]       {sof, eol, word[31:0]} of the FIFO head (0 when empty)
//   out_valid            FIFO not empty
//   out_ready            consumer accept; pop = out_valid && out_ready
//   line_cnt             completed lines in the current frame, saturating
//   ovf, ovf_clr         sticky FIFO overflow flag and its clear
module daq_pixel_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LINE_CNT_W = 12
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [7:0]            data_in,
    input  logic [2:0]            state,
    output logic [33:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] ST_FOT   = 3'b001;
    localparam logic [2:0] ST_WR_EN = 3'b010;

    logic [2:0]  state_d;
    logic [1:0]  byte_idx;
    logic [31:0] acc;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        byte_vld;
    logic        last;
    logic        fot_rise;
    logic        data_push;
    logic        data_sof;
    logic [31:0] merged;
    logic [33:0] data_word;

    logic        hdr_push;
    logic [33:0] hdr_word;

    logic          slot0_v;
    logic          slot1_v;
    logic [33:0]   slot0;
    logic          pop;
    logic [CW-1:0] free;
    logic          acc0;
    logic          acc1;
    logic          drop;
    logic [CW-1:0] n_wr;

`ifdef DAQ_PACK_HDR_EN
    logic [15:0] frame_cnt;

    assign hdr_push = fot_rise;
    assign hdr_word = {2'b10, 16'hA5A5, frame_cnt};
    assign data_sof = 1'b0;
`else
    logic sof_arm;

    assign hdr_push = 1'b0;
    assign hdr_word = '0;
    assign data_sof = sof_arm;
`endif

    // Byte qualification and packing
    always_comb begin
        byte_vld  = (state_d == ST_WR_EN);
        last      = byte_vld && (state != ST_WR_EN);
        fot_rise  = (state == ST_FOT) && (state_d != ST_FOT);
        merged    = acc | (32'(data_in) << {byte_idx, 3'b000});
        data_push = byte_vld && ((byte_idx == 2'd3) || last);
        data_word = {data_sof, last, merged};
    end

    // FIFO admission: up to two words per cycle (data first, then header)
    always_comb begin
        slot0_v = data_push || hdr_push;
        slot1_v = data_push && hdr_push;
        slot0   = data_push ? data_word : hdr_word;
        pop     = (count != '0) && out_ready;
        free    = CW'(FIFO_DEPTH) - count + CW'(pop);
        acc0    = slot0_v && (free != '0);
        acc1    = slot1_v && (free >= CW'(2));
        drop    = (slot0_v && !acc0) || (slot1_v && !acc1);
        n_wr    = CW'(acc0) + CW'(acc1);
    end

    // FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            if (acc0) mem[wr_ptr] <= slot0;
            if (acc1) mem[wr_ptr + AW'(1)] <= hdr_word;
        end
    end

    // Control state
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_d  <= 3'b000;
            byte_idx <= 2'd0;
            acc      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            line_cnt <= '0;
            ovf      <= 1'b0;
`ifdef DAQ_PACK_HDR_EN
            frame_cnt <= 16'd0;
`else
            sof_arm   <= 1'b0;
`endif
        end else begin
            state_d <= state;

            if (byte_vld) begin
                if (data_push) begin
                    acc      <= '0;
                    byte_idx <= 2'd0;
                end else begin
                    acc      <= merged;
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            wr_ptr <= wr_ptr + AW'(n_wr);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + n_wr - CW'(pop);

            // A frame start wins over a line closing in the same cycle
            if (fot_rise) begin
                line_cnt <= '0;
            end else if (last && (line_cnt != '1)) begin
                line_cnt <= line_cnt + LINE_CNT_W'(1);
            end

            // An overflow in the clear cycle keeps the flag set
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

`ifdef DAQ_PACK_HDR_EN
            if (fot_rise) frame_cnt <= frame_cnt + 16'd1;
`else
            // Arming wins over the push that would consume it
            if (state == ST_FOT) begin
                sof_arm <= 1'b1;
            end else if (data_push) begin
                sof_arm <= 1'b0;
            end
`endif
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_daq_pixel_packer.sv
// Directed testbench for daq_pixel_packer.
module tb_daq_pixel_packer;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_FOT  = 3'b001;
    localparam logic [2:0] S_WR   = 3'b010;
    localparam logic [2:0] S_ROT  = 3'b100;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  data_in;
    logic [2:0]  state;
    logic [33:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] line_cnt;
    logic        ovf;
    logic        ovf_clr;

    int tests  = 0;
    int errors = 0;

    logic [33:0] q [$];

    daq_pixel_packer #(.FIFO_DEPTH(4), .LINE_CNT_W(12)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data_in   (data_in),
        .state     (state),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .line_cnt  (line_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every word the consumer accepts at the coming rising edge
    always @(negedge sys_clk) begin
        if (sys_rst_n && out_valid && out_ready) q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // n bytes base, base+1, ... ; data trails state by one cycle; ends in ROT.
    // pop_at >= 0 drives out_ready high only in that iteration.
    task automatic send_line(input int n, input logic [7:0] base, input int pop_at);
        for (int i = 0; i <= n; i++) begin
            state   = (i < n) ? S_WR : S_ROT;
            data_in = (i > 0) ? base + 8'(i - 1) : 8'h00;
            if (pop_at >= 0) out_ready = (i == pop_at);
            tick();
        end
    endtask

    task automatic check_q(input string tag, input int idx, input logic [33:0] exp);
        logic [33:0] got;
        got = (idx < q.size()) ? q[idx] : 34'h0;
        check(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        data_in   = 8'h00;
        state     = S_IDLE;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_line",  64'(line_cnt),  64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        sys_rst_n = 1'b1;
        tick();

`ifdef DAQ_PACK_HDR_EN
        // Two frames, each led by a header word
        q.delete();
        state = S_FOT; tick(2);
        send_line(4, 8'h01, -1);
        state = S_FOT; tick(2);
        send_line(4, 8'h05, -1);
        tick(3);
        check("hdr_qsize", 64'(q.size()), 64'd4);
        check_q("hdr_w0", 0, {2'b10, 32'hA5A50000});
        check_q("hdr_w1", 1, {2'b01, 32'h04030201});
        check_q("hdr_w2", 2, {2'b10, 32'hA5A50001});
        check_q("hdr_w3", 3, {2'b01, 32'h08070605});
        check("hdr_line", 64'(line_cnt), 64'd1);
        check("hdr_ovf",  64'(ovf),      64'd0);
`else
        // Frame start then 8-byte line
        q.delete();
        state = S_FOT; tick(3);
        send_line(8, 8'h01, -1);
        tick(3);
        check("l1_qsize", 64'(q.size()), 64'd2);
        check_q("l1_w0", 0, {2'b10, 32'h04030201});
        check_q("l1_w1", 1, {2'b01, 32'h08070605});
        check("l1_line", 64'(line_cnt), 64'd1);

        // 6-byte line leaves a partial word; next line restarts at lane 0
        q.delete();
        send_line(6, 8'h11, -1);
        tick(2);
        check("l2_line", 64'(line_cnt), 64'd2);
        send_line(2, 8'h21, -1);
        tick(3);
        check("l2_qsize", 64'(q.size()), 64'd3);
        check_q("l2_w0", 0, {2'b00, 32'h14131211});
        check_q("l2_w1", 1, {2'b01, 32'h00001615});
        check_q("l2_w2", 2, {2'b01, 32'h00002221});
        check("l3_line", 64'(line_cnt), 64'd3);

        // Overflow: 24-byte line with consumer stalled
        q.delete();
        out_ready = 1'b0;
        state = S_FOT; tick();
        send_line(24, 8'h40, -1);
        tick(2);
        check("ov_flag",  64'(ovf),       64'd1);
        check("ov_valid", 64'(out_valid), 64'd1);
        check("ov_head",  64'(out_data),  64'({2'b10, 32'h43424140}));
        check("ov_line",  64'(line_cnt),  64'd1);
        ovf_clr = 1'b1; tick();
        ovf_clr = 1'b0;
        check("ov_clr",   64'(ovf),       64'd0);
        out_ready = 1'b1;
        tick(6);
        check("ov_qsize", 64'(q.size()), 64'd4);
        check_q("ov_w0", 0, {2'b10, 32'h43424140});
        check_q("ov_w1", 1, {2'b00, 32'h47464544});
        check_q("ov_w2", 2, {2'b00, 32'h4B4A4948});
        check_q("ov_w3", 3, {2'b00, 32'h4F4E4D4C});

        // Full FIFO with a pop in the same cycle as the fifth push
        q.delete();
        out_ready = 1'b0;
        send_line(20, 8'h50, 20);
        out_ready = 1'b0;
        tick();
        check("fp_ovf",  64'(ovf),      64'd0);
        check("fp_head", 64'(out_data), 64'({2'b00, 32'h57565554}));
        out_ready = 1'b1;
        tick(6);
        check("fp_qsize", 64'(q.size()), 64'd5);
        check_q("fp_w0", 0, {2'b00, 32'h53525150});
        check_q("fp_w1", 1, {2'b00, 32'h57565554});
        check_q("fp_w2", 2, {2'b00, 32'h5B5A5958});
        check_q("fp_w3", 3, {2'b00, 32'h5F5E5D5C});
        check_q("fp_w4", 4, {2'b01, 32'h63626160});

        // Reset mid-line with one word buffered and two bytes pending
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            state   = S_WR;
            data_in = (i > 0) ? 8'h60 + 8'(i) : 8'h00;
            tick();
        end
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        sys_rst_n = 1'b0;
        state     = S_IDLE;
        tick();
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data",  64'(out_data),  64'd0);
        check("mr_line",  64'(line_cnt),  64'd0);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_line(4, 8'h71, -1);
        tick(3);
        check("mr_qsize", 64'(q.size()), 64'd1);
        check_q("mr_w0", 0, {2'b01, 32'h74737271});
        check("mr_line2", 64'(line_cnt), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
